// File: rtl/cr16_cond_pkg.sv
// Shared condition-code, flag-index and FSM-state definitions for the CR16
// branch path. Also used by the conditional-move logic.
package cr16_cond_pkg;

  // 4-bit condition codes
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // PSR flag bit positions (FLCNZ)
  localparam int FLAG_F = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } br_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: (cond, flags) -> taken.
module cond_eval
  import cr16_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic f, l, c, n, z;
  assign f = flags[FLAG_F];
  assign l = flags[FLAG_L];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];

  // Decode condition code against the flag bits
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = ~z;
      CC_CS: taken = c;
      CC_CC: taken = ~c;
      CC_HI: taken = l;
      CC_LS: taken = ~l;
      CC_GT: taken = n;
      CC_LE: taken = ~n;
      CC_FS: taken = f;
      CC_FC: taken = ~f;
      CC_LO: taken = ~l & ~z;
      CC_HS: taken = l | z;
      CC_LT: taken = ~n & ~z;
      CC_GE: taken = n | z;
      CC_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit: captures a branch request from decode, waits for
// any in-flight PSR update, evaluates the condition once, and hands the
// registered taken/target result to fetch over valid/ready.
// Optional feature: define BRANCH_STATS_EN to build the saturating
// taken-branch counter on taken_cnt (tied to zero otherwise).
module branch_resolve
  import cr16_cond_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DISP_W = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [DISP_W-1:0] br_disp,
  input  logic [4:0]        flag_in,
  input  logic              flag_pending,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [PC_W-1:0]   res_target,
  output logic [15:0]       taken_cnt
);

  typedef struct packed {
    logic [3:0]        cond;
    logic [PC_W-1:0]   pc;
    logic [DISP_W-1:0] disp;
  } br_req_t;

  br_state_t state;
  br_req_t   req;

  logic            eval_taken;
  logic [PC_W-1:0] disp_off;
  logic [PC_W-1:0] tgt_taken;
  logic [PC_W-1:0] tgt_seq;

  cond_eval u_cond_eval (
    .cond  (req.cond),
    .flags (flag_in),
    .taken (eval_taken)
  );

  // Halfword displacement: sign-extend and shift left by one
  assign disp_off  = {{(PC_W-DISP_W-1){req.disp[DISP_W-1]}}, req.disp, 1'b0};
  assign tgt_taken = req.pc + disp_off;
  assign tgt_seq   = req.pc + PC_W'(2);

  // Request/evaluate/respond FSM with registered handshake outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      req        <= '0;
      br_ready   <= 1'b1;
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (br_valid) begin
            req.cond <= br_cond;
            req.pc   <= br_pc;
            req.disp <= br_disp;
            br_ready <= 1'b0;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // Flags are only trusted once no PSR write is in flight
          if (!flag_pending) begin
            res_taken  <= eval_taken;
            res_target <= eval_taken ? tgt_taken : tgt_seq;
            res_valid  <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            br_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          br_ready  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] cnt_q;

  // Count taken results on the consumer handshake, saturating at all-ones
  always_ff @(posedge CLK) begin
    if (RESET)
      cnt_q <= '0;
    else if (state == ST_RESP && res_ready && res_taken && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: vector table for condition/target
// coverage plus hand sequences for stall, backpressure and reset.
module tb_branch_resolve;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [15:0] br_pc;
  logic [8:0]  br_disp;
  logic [4:0]  flag_in;
  logic        flag_pending;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic [15:0] res_target;
  logic [15:0] taken_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  branch_resolve #(.PC_W(16), .DISP_W(9)) dut (
    .CLK(CLK), .RESET(RESET),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_pc(br_pc), .br_disp(br_disp),
    .flag_in(flag_in), .flag_pending(flag_pending),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_taken(res_taken), .res_target(res_target),
    .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic [3:0]  cond;
    logic [4:0]  flags;
    logic [15:0] pc;
    logic [8:0]  disp;
    logic        exp_taken;
    logic [15:0] exp_target;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request; pend = EVAL cycles with flag_pending high,
  // hold = RESP cycles with res_ready low before the handshake.
  task automatic do_req(input string name, input logic [3:0] cond, input logic [15:0] pc,
                        input logic [8:0] disp, input logic [4:0] flags_pend,
                        input logic [4:0] flags, input int pend, input int hold,
                        input logic exp_taken, input logic [15:0] exp_target);
    int cyc;
    logic [15:0] tgt0;
    chk({name, " br_ready idle"}, br_ready, 1'b1);
    br_valid = 1'b1; br_cond = cond; br_pc = pc; br_disp = disp;
    tick();
    br_valid = 1'b0; br_cond = ~cond; br_pc = ~pc; br_disp = ~disp;
    flag_pending = (pend > 0);
    flag_in = (pend > 0) ? flags_pend : flags;
    chk({name, " br_ready eval"}, br_ready, 1'b0);
    cyc = 0;
    while (!res_valid && cyc < 30) begin
      tick();
      cyc++;
      if (cyc == pend) begin
        flag_pending = 1'b0;
        flag_in = flags;
      end
    end
    chk({name, " latency"}, cyc, pend + 1);
    chk({name, " taken"}, res_taken, exp_taken);
    chk({name, " target"}, res_target, exp_target);
    // later flag changes must not disturb the registered result
    flag_in = ~flags;
    tgt0 = res_target;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, " hold valid"}, res_valid, 1'b1);
      chk({name, " hold target"}, res_target, tgt0);
      chk({name, " hold taken"}, res_taken, exp_taken);
      chk({name, " hold br_ready"}, br_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`ifdef BRANCH_STATS_EN
    if (exp_taken) exp_cnt++;
`endif
    chk({name, " valid drop"}, res_valid, 1'b0);
    chk({name, " br_ready back"}, br_ready, 1'b1);
    chk({name, " taken_cnt"}, taken_cnt, exp_cnt[15:0]);
  endtask

  initial begin
    vecs[0]  = '{4'h0, 5'b00001, 16'h0100, 9'h010, 1'b1, 16'h0120};
    vecs[1]  = '{4'h0, 5'b00001, 16'h0100, 9'h1F0, 1'b1, 16'h00E0};
    vecs[2]  = '{4'h0, 5'b00000, 16'h0100, 9'h1F0, 1'b0, 16'h0102};
    vecs[3]  = '{4'hE, 5'b00000, 16'hFFFE, 9'h002, 1'b1, 16'h0002};
    vecs[4]  = '{4'h1, 5'b00000, 16'h0200, 9'h004, 1'b1, 16'h0208};
    vecs[5]  = '{4'h2, 5'b00100, 16'h0300, 9'h0FF, 1'b1, 16'h04FE};
    vecs[6]  = '{4'h3, 5'b00100, 16'h0300, 9'h0FF, 1'b0, 16'h0302};
    vecs[7]  = '{4'h5, 5'b00000, 16'h1000, 9'h100, 1'b1, 16'h0E00};
    vecs[8]  = '{4'h7, 5'b00010, 16'h2000, 9'h001, 1'b0, 16'h2002};
    vecs[9]  = '{4'h8, 5'b10000, 16'h2000, 9'h003, 1'b1, 16'h2006};
    vecs[10] = '{4'h9, 5'b10000, 16'h4000, 9'h003, 1'b0, 16'h4002};
    vecs[11] = '{4'hA, 5'b00000, 16'h5000, 9'h008, 1'b1, 16'h5010};
    vecs[12] = '{4'hA, 5'b00001, 16'h5000, 9'h008, 1'b0, 16'h5002};
    vecs[13] = '{4'hB, 5'b01000, 16'h6000, 9'h1FF, 1'b1, 16'h5FFE};
    vecs[14] = '{4'hB, 5'b00000, 16'h6000, 9'h1FF, 1'b0, 16'h6002};
    vecs[15] = '{4'hC, 5'b00010, 16'h7000, 9'h010, 1'b0, 16'h7002};
    vecs[16] = '{4'hD, 5'b00001, 16'h7000, 9'h010, 1'b1, 16'h7020};
    vecs[17] = '{4'hF, 5'b11111, 16'h8000, 9'h010, 1'b0, 16'h8002};
    vecs[18] = '{4'h6, 5'b00010, 16'h8000, 9'h020, 1'b1, 16'h8040};
    vecs[19] = '{4'h4, 5'b00000, 16'h9000, 9'h020, 1'b0, 16'h9002};

    RESET = 1'b1; br_valid = 1'b0; br_cond = '0; br_pc = '0; br_disp = '0;
    flag_in = '0; flag_pending = 1'b0; res_ready = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    chk("reset br_ready", br_ready, 1'b1);
    chk("reset res_valid", res_valid, 1'b0);
    chk("reset res_taken", res_taken, 1'b0);
    chk("reset res_target", res_target, 16'h0000);
    chk("reset taken_cnt", taken_cnt, 16'h0000);

    // res_ready outside RESP is ignored
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle res_ready valid", res_valid, 1'b0);
    chk("idle res_ready br_ready", br_ready, 1'b1);

    for (int i = 0; i < 20; i++)
      do_req($sformatf("vec%0d", i), vecs[i].cond, vecs[i].pc, vecs[i].disp,
             5'b00000, vecs[i].flags, 0, (i % 3), vecs[i].exp_taken, vecs[i].exp_target);

    // stall: flags sampled only after pending clears
    do_req("pend3", 4'h4, 16'hA000, 9'h004, 5'b00000, 5'b01000, 3, 4, 1'b1, 16'hA008);
    // stall where the pending-time flags would have taken the branch
    do_req("pend2", 4'h0, 16'hB000, 9'h004, 5'b00001, 5'b00000, 2, 0, 1'b0, 16'hB002);

    // reset pulsed during EVAL discards the request
    br_valid = 1'b1; br_cond = 4'hE; br_pc = 16'hC000; br_disp = 9'h004;
    flag_pending = 1'b1;
    tick();
    br_valid = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0; flag_pending = 1'b0;
    exp_cnt = 0;
    chk("rst eval br_ready", br_ready, 1'b1);
    chk("rst eval res_valid", res_valid, 1'b0);
    chk("rst eval taken_cnt", taken_cnt, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst eval no result", res_valid, 1'b0);
    end

    // reset during RESP drops the pending result
    br_valid = 1'b1; br_cond = 4'hE; br_pc = 16'hD000; br_disp = 9'h004;
    tick();
    br_valid = 1'b0;
    tick();
    chk("rst resp valid before", res_valid, 1'b1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst resp valid", res_valid, 1'b0);
    chk("rst resp br_ready", br_ready, 1'b1);
    chk("rst resp target", res_target, 16'h0000);

    // counter after reset: 3 taken, 2 not taken
    do_req("cnt0", 4'hE, 16'h0010, 9'h001, 5'b0, 5'b00000, 0, 0, 1'b1, 16'h0012);
    do_req("cnt1", 4'hF, 16'h0010, 9'h001, 5'b0, 5'b00000, 0, 0, 1'b0, 16'h0012);
    do_req("cnt2", 4'h0, 16'h0020, 9'h002, 5'b0, 5'b00001, 0, 0, 1'b1, 16'h0024);
    do_req("cnt3", 4'h1, 16'h0020, 9'h002, 5'b0, 5'b00001, 0, 0, 1'b0, 16'h0022);
    do_req("cnt4", 4'h2, 16'h0030, 9'h003, 5'b0, 5'b00100, 0, 0, 1'b1, 16'h0036);
`ifdef BRANCH_STATS_EN
    chk("cnt total", taken_cnt, 16'd3);
`else
    chk("cnt total", taken_cnt, 16'd0);
`endif
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_cnt = 0;
    chk("cnt after reset", taken_cnt, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution unit. It consumes the processor status flags produced by the PSR (FLCNZ order) and resolves conditional branches. For each accepted branch request it evaluates the 4-bit condition code against the current flags, computes the next PC, and returns the result over a valid/ready handshake. It sits between the decode stage (request side) and the fetch/PC logic (result side). It stalls while a PSR update is still in flight.

## Interface
Parameters:
- PC_W, 16: PC and target width
- DISP_W, 9: signed branch displacement width, in halfwords

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- br_valid  in  1  branch request valid
- br_ready  out  1  unit can accept a request; high only in IDLE
- br_cond  in  4  condition code
- br_pc  in  PC_W  address of the branch instruction
- br_disp  in  DISP_W  signed displacement, in halfwords
- flag_in  in  5  PSR flag_out: [4]=F, [3]=L, [2]=C, [1]=N, [0]=Z
- flag_pending  in  1  a flag-writing ALU op will update the PSR this cycle
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_taken  out  1  branch taken
- res_target  out  PC_W  next PC
- taken_cnt  out  16  taken-branch count (only with BRANCH_STATS_EN)

## Operation
- States: IDLE, EVAL, RESP. Reset state is IDLE.
- IDLE:
  - br_ready=1.
  - On br_valid, capture cond, pc and disp, then go to EVAL.
- EVAL:
  - br_ready=0.
  - If flag_pending=1, stay in EVAL.
  - Else sample flag_in, compute taken and target, and register both. Go to RESP.
- RESP:
  - res_valid=1; res_taken and res_target are held stable.
  - On res_ready=1, go to IDLE. res_valid drops on that edge.
- Condition codes (Z, C, L, N, F are flag bits):
  - 0000 EQ: Z=1
  - 0001 NE: Z=0
  - 0010 CS: C=1
  - 0011 CC: C=0
  - 0100 HI: L=1
  - 0101 LS: L=0
  - 0110 GT: N=1
  - 0111 LE: N=0
  - 1000 FS: F=1
  - 1001 FC: F=0
  - 1010 LO: L=0 and Z=0
  - 1011 HS: L=1 or Z=1
  - 1100 LT: N=0 and Z=0
  - 1101 GE: N=1 or Z=1
  - 1110 UC: always taken
  - 1111: never taken
- Target computation:
  - Taken: res_target = pc + (sext(disp) << 1), modulo 2^PC_W.
  - Not taken: res_target = pc + 2, modulo 2^PC_W.
- Flags are sampled exactly once per request, in the first EVAL cycle with flag_pending=0. Later flag changes do not affect a registered result.

## Timing
- Reset values: state=IDLE, res_valid=0, res_taken=0, res_target=0, taken_cnt=0. br_ready=1 from the first cycle after the reset edge.
- Minimum latency: request accepted at edge k, flags sampled at edge k+1, res_valid=1 after edge k+1.
- Each pending cycle adds one cycle of latency.
- Throughput: at most one request per 3 cycles, since br_ready is low in EVAL and RESP.
- A request presented while br_ready=0 is not captured. The requester holds it until br_ready=1.
- res_ready is ignored outside RESP.
- RESET mid-operation (EVAL or RESP): the request is discarded, no res_valid is produced, and the unit returns to IDLE.
- RESET has priority over every other input.

## Configuration
- Macro BRANCH_STATS_EN.
- Defined:
  - taken_cnt increments on each RESP-to-IDLE handshake with res_taken=1.
  - It saturates at 16'hFFFF.
  - It clears on RESET.
- Undefined:
  - The counter is not built.
  - taken_cnt is tied to 16'h0000.

## Structure
- Package cr16_cond_pkg:
  - 4-bit condition-code constants (EQ through never)
  - flag bit indices (F=4, L=3, C=2, N=1, Z=0)
  - state enum (IDLE/EVAL/RESP)
- Sub-module cond_eval: purely combinational, (cond, flags) -> taken. It is reused later by conditional-move logic.

## Test plan
- EQ taken: flags 5'b00001, cond 0000, pc 16'h0100, disp 9'h010 -> res_taken=1, res_target=16'h0120, res_valid after 2 edges.
- Negative displacement and not-taken:
  - flags 5'b00001, cond 0000, pc 16'h0100, disp 9'h1F0 -> target 16'h00E0.
  - Same with flags 5'b00000 -> res_taken=0, target 16'h0102.
- Wrap-around: cond 1110, pc 16'hFFFE, disp 9'h002 -> res_target 16'h0002.
- Pending stall:
  - flag_pending high for 3 EVAL cycles with flag_in 5'b00000.
  - Then low with flag_in 5'b01000 and cond 0100.
  - Expect res_taken=1 and res_valid 3 cycles later than the minimum.
- Backpressure and reset:
  - res_ready low for 4 cycles -> res_valid and res_target stable, br_ready=0 throughout.
  - RESET pulsed during EVAL -> no res_valid, br_ready=1 on the next cycle.
- With BRANCH_STATS_EN: 3 taken and 2 not-taken handshakes -> taken_cnt=3. After RESET -> 0.
